powlib_iprdburst: RTL
=====================

// Module: powlib_iprdburst
// PURPOSE
//  Burst read requester placed directly upstream of powlib_ipram. Takes one command (start addr, return addr,
//  length) and issues LEN packed POWLIB_OP_READ requests on the RAM write port, with credit-limited outstanding
//  reads. Collects the in-order read responses from the RAM read port and forwards them as a data stream with last/done.
// PARAMETERS
//  ID      "IPRDBURST"  string identifier for debug prints
//  EDBG    0            enable debug $display per issued request / received response
//  B_BPD   4            bus bytes per data (power of 2); B_DW=`POWLIB_BW*B_BPD, B_BEW=B_BPD
//  B_AW    `POWLIB_BW*B_BPD  bus address width (<= B_DW); B_WW=`POWLIB_OPW+B_BEW+B_DW
//  LENW    16           command length width
//  MAX_OUT 8            max outstanding (issued, not yet streamed) reads, 1..2**LENW-1
// PORTS
//  clk       in   1      clock
//  rst       in   1      asynchronous, active-low reset
//  cmdaddr   in   B_AW   first RAM byte address of burst
//  cmdret    in   B_AW   first return address (placed in request data field)
//  cmdlen    in   LENW   number of words to read (0 illegal)
//  cmdvld    in   1      command valid
//  cmdrdy    out  1      command ready (high only in IDLE)
//  wraddr    out  B_AW   request address -> ipram wraddr
//  wrdata    out  B_WW   packed request -> ipram wrdata
//  wrvld     out  1      request valid
//  wrrdy     in   1      request ready
//  rspaddr   in   B_AW   response return address <- ipram rdaddr
//  rspdata   in   B_WW   packed response <- ipram rddata
//  rspvld    in   1      response valid
//  rsprdy    out  1      response ready
//  strdata   out  B_DW   unpacked read data
//  strvld    out  1      stream valid
//  strrdy    in   1      stream ready
//  strlast   out  1      marks final word of burst
//  done      out  1      one-cycle pulse after final stream handshake
//  err       out  1      sticky error flag
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; cmdrdy=1, wrvld=0, rsprdy=0, strvld=0, strlast=0, done=0, err=0, all counters 0.
//  - FSM IDLE->ISSUE on cmdvld&&cmdrdy with cmdlen!=0; command fields registered. cmdlen==0: err set, stay IDLE.
//  - ISSUE: wrvld=1 when issued<len && outst<MAX_OUT. Request k (0-based): wraddr=cmdaddr+k*B_BPD,
//    wrdata=powlib_ippackintr0(data={zero-ext cmdret+k*B_BPD}, be=all ones, op=`POWLIB_OP_READ). Address sums mod 2**B_AW.
//    wraddr/wrdata held stable while wrvld&&!wrrdy. First wrvld one cycle after command handshake.
//  - ISSUE->DRAIN when issued==len; DRAIN->IDLE on final stream handshake (strvld&&strrdy&&strlast); done=1 that next cycle.
//  - Response path (ISSUE/DRAIN): combinational pass-through, rsprdy=strrdy, strvld=rspvld,
//    strdata=unpacked rspdata data field. In IDLE rsprdy=0, strvld=0.
//  - strlast=1 when received==len-1 and strvld. received increments on stream handshake.
//  - outst: +1 on request handshake, -1 on stream handshake, unchanged when both same cycle; never exceeds MAX_OUT.
//  - Responses assumed in order (ipram guarantee); no reordering buffer.
//  - len==1: one request, strlast on first response. Back-to-back command accepted cycle after done.
//  - Reset mid-burst: aborts immediately; downstream ipram must be reset together (in-flight responses not tracked).
// CONFIGURATION
//  POWLIB_IPRDBURST_CHK_EN defined: each accepted response checked: rspaddr==cmdret+received*B_BPD and unpacked
//   op==`POWLIB_OP_WRITE; mismatch sets err (sticky until reset); EDBG prints ID, expected, actual. Data still forwarded.
//  Undefined: no compare logic; err set only by cmdlen==0.
// TESTING
//  1 cmdaddr=0x10,cmdret=0x1000,len=4, strrdy=1 -> wraddr 0x10,0x14,0x18,0x1C; ret 0x1000..0x100C; strlast on 4th; done 1 cycle later.
//  2 len=20,MAX_OUT=8,strrdy=0 -> exactly 8 requests then wrvld=0; strrdy=1 -> remaining 12 issued, 20 words streamed in order.
//  3 cmdaddr=0xFFFFFFF8,len=3 -> wraddr 0xFFFFFFF8,0xFFFFFFFC,0x00000000 (wrap).
//  4 cmdlen=0 -> err=1, cmdrdy stays 1, no wrvld; next valid command still runs.
//  5 CHK_EN, bench corrupts rspaddr of word 2 -> err=1 from cycle after that handshake, burst completes, done pulses.
//  6 rst=0 asserted mid-ISSUE with wrvld=1 -> all outputs to reset values asynchronously, cmdrdy=1 after release.

Source files
------------

// File: rtl/powlib_iprdburst.sv
// Burst read requester feeding powlib_ipram; issues credit-limited reads and streams the responses.
// Define POWLIB_IPRDBURST_CHK_EN to check every response's return address and opcode.
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 2'd0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 2'd1
`endif

module powlib_iprdburst #(
    parameter string ID      = "IPRDBURST",
    parameter int    EDBG    = 0,
    parameter int    B_BPD   = 4,
    parameter int    B_AW    = `POWLIB_BW*B_BPD,
    parameter int    LENW    = 16,
    parameter int    MAX_OUT = 8,
    localparam int   B_DW    = `POWLIB_BW*B_BPD,
    localparam int   B_BEW   = B_BPD,
    localparam int   B_WW    = `POWLIB_OPW+B_BEW+B_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_AW-1:0] cmdaddr,
    input  logic [B_AW-1:0] cmdret,
    input  logic [LENW-1:0] cmdlen,
    input  logic            cmdvld,
    output logic            cmdrdy,
    output logic [B_AW-1:0] wraddr,
    output logic [B_WW-1:0] wrdata,
    output logic            wrvld,
    input  logic            wrrdy,
    input  logic [B_AW-1:0] rspaddr,
    input  logic [B_WW-1:0] rspdata,
    input  logic            rspvld,
    output logic            rsprdy,
    output logic [B_DW-1:0] strdata,
    output logic            strvld,
    input  logic            strrdy,
    output logic            strlast,
    output logic            done,
    output logic            err
);

    localparam int OPW = `POWLIB_OPW;
    localparam int OW  = $clog2(MAX_OUT+1);
    localparam logic [B_AW-1:0] STEP = B_AW'(B_BPD);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    function automatic logic [B_WW-1:0] powlib_ippackintr0(
        input logic [B_DW-1:0]  data,
        input logic [B_BEW-1:0] be,
        input logic [OPW-1:0]   op
    );
        return {op, be, data};
    endfunction

    state_t          state_q, state_d;
    logic [B_AW-1:0] addr_q, addr_d;
    logic [B_AW-1:0] ret_q, ret_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] issued_q, issued_d;
    logic [LENW-1:0] recv_q, recv_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            active, req_hs, str_hs, last_hs, chk_bad;
    logic            unused_rsp;

    always_comb begin
        active  = state_q != IDLE;
        cmdrdy  = state_q == IDLE;
        wrvld   = (state_q == ISSUE) && (issued_q < len_q)
                  && (outst_q < OW'(MAX_OUT));
        wraddr  = addr_q;
        wrdata  = powlib_ippackintr0(B_DW'(ret_q), {B_BEW{1'b1}},
                                     `POWLIB_OP_READ);
        rsprdy  = active && strrdy;
        strvld  = active && rspvld;
        strdata = rspdata[B_DW-1:0];
        strlast = strvld && (recv_q == len_q - 1'b1);
        req_hs  = wrvld && wrrdy;
        str_hs  = strvld && strrdy;
        last_hs = str_hs && strlast;
        done    = done_q;
        err     = err_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ret_d    = ret_q;
        len_d    = len_q;
        issued_d = issued_q;
        recv_d   = recv_q;
        outst_d  = outst_q;
        done_d   = 1'b0;
        err_d    = err_q | chk_bad;
        unique case (state_q)
            IDLE: begin
                if (cmdvld) begin
                    if (cmdlen == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        addr_d   = cmdaddr;
                        ret_d    = cmdret;
                        len_d    = cmdlen;
                        issued_d = '0;
                        recv_d   = '0;
                        outst_d  = '0;
                    end
                end
            end
            ISSUE, DRAIN: begin
                if (req_hs) begin
                    issued_d = issued_q + 1'b1;
                    addr_d   = addr_q + STEP;
                    ret_d    = ret_q + STEP;
                end
                if (str_hs)
                    recv_d = recv_q + 1'b1;
                if (req_hs && !str_hs)
                    outst_d = outst_q + 1'b1;
                else if (!req_hs && str_hs)
                    outst_d = outst_q - 1'b1;
                // A fast final response can arrive before ISSUE has moved to DRAIN.
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (state_q == ISSUE && issued_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            ret_q    <= '0;
            len_q    <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ret_q    <= ret_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

`ifdef POWLIB_IPRDBURST_CHK_EN
    logic [B_AW-1:0] exp_q, exp_d;

    always_comb begin
        exp_d   = exp_q;
        chk_bad = 1'b0;
        if (state_q == IDLE && cmdvld)
            exp_d = cmdret;
        else if (str_hs) begin
            exp_d   = exp_q + STEP;
            chk_bad = (rspaddr != exp_q)
                      || (rspdata[B_WW-1 -: OPW] != `POWLIB_OP_WRITE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            exp_q <= '0;
        else
            exp_q <= exp_d;
    end

    assign unused_rsp = ^rspdata[B_DW +: B_BEW];
`else
    assign chk_bad    = 1'b0;
    assign unused_rsp = ^{rspaddr, rspdata[B_WW-1:B_DW]};
`endif

endmodule
